// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: widths, NOP encoding, fault causes
// and the IF/ID pipeline record.
package instruction_fetch_unit_pkg;

  localparam int XLEN    = 32;
  localparam int IMEM_AW = 10;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FF_NONE     = 2'b00,
    FF_MISALIGN = 2'b01,
    FF_RANGE    = 2'b10
  } fetch_fault_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] inst;
    fetch_fault_e    fault;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    valid:    1'b0,
    pc:       '0,
    pc_plus4: '0,
    inst:     NOP_INST,
    fault:    FF_NONE
  };

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: flush loads a bubble and wins over stall;
// stall holds the current contents.
module if_id_register
  import instruction_fetch_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= IF_ID_BUBBLE;
    end else if (flush) begin
      q <= IF_ID_BUBBLE;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, addresses instruction memory and captures the
// returned word (or a NOP plus fault cause) into the IF/ID register.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC            = RESET_PC_DEFAULT,
  parameter int              DATA_WIDTH          = XLEN,
  parameter int              INST_MEM_ADDR_WIDTH = IMEM_AW
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall_i,
  input  logic                           redirect_i,
  input  logic [DATA_WIDTH-1:0]          redirect_pc_i,
  output logic [INST_MEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0]          imem_data_i,
  output logic [DATA_WIDTH-1:0]          pc_o,
  output logic                           if_id_valid_o,
  output logic [DATA_WIDTH-1:0]          if_id_pc_o,
  output logic [DATA_WIDTH-1:0]          if_id_pc_plus4_o,
  output logic [DATA_WIDTH-1:0]          if_id_inst_o,
  output logic [1:0]                     if_id_fault_o
);

  // Misalignment outranks out-of-range; a faulted fetch still advances.
  function automatic fetch_fault_e classify_fault(input logic [DATA_WIDTH-1:0] pc);
    if (pc[1:0] != 2'b00) return FF_MISALIGN;
    if ((pc >> (INST_MEM_ADDR_WIDTH + 2)) != '0) return FF_RANGE;
    return FF_NONE;
  endfunction

  logic [DATA_WIDTH-1:0] pc_p0;
  logic [DATA_WIDTH-1:0] pc_plus4_p0;
  fetch_fault_e          fault_p0;
  if_id_t                capture_p0;
  if_id_t                if_id_p1;

  assign pc_plus4_p0 = pc_p0 + DATA_WIDTH'(4);
  assign fault_p0    = classify_fault(pc_p0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0 <= RESET_PC;
    end else if (redirect_i) begin
      pc_p0 <= redirect_pc_i;
    end else if (!stall_i) begin
      pc_p0 <= pc_plus4_p0;
    end
  end

  assign imem_addr_o = pc_p0[INST_MEM_ADDR_WIDTH+1:2];
  assign pc_o        = pc_p0;

  assign capture_p0 = '{
    valid:    1'b1,
    pc:       pc_p0,
    pc_plus4: pc_plus4_p0,
    inst:     (fault_p0 == FF_NONE) ? imem_data_i : NOP_INST,
    fault:    fault_p0
  };

  // ---- stage boundary: IF -> IF/ID ----
  if_id_register u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall_i),
    .flush (redirect_i),
    .d     (capture_p0),
    .q     (if_id_p1)
  );

  assign if_id_valid_o    = if_id_p1.valid;
  assign if_id_pc_o       = if_id_p1.pc;
  assign if_id_pc_plus4_o = if_id_p1.pc_plus4;
  assign if_id_inst_o     = if_id_p1.inst;
  assign if_id_fault_o    = if_id_p1.fault;

endmodule
